// File: rtl/iter_alu.sv
// Registered execute-stage ALU with RV32M multiply/divide: iterative shift-add multiplier and
// restoring divider behind valid/ready handshakes. Define ITER_ALU_FAST_MUL_EN for a 1-cycle multiplier.
module iter_alu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      alu_op,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_out,
    output logic            busy
);
    localparam int SHW = $clog2(XLEN);
    localparam int CW  = $clog2(XLEN + 1);

    localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB  = 5'd1,  OP_AND    = 5'd2,  OP_OR    = 5'd3;
    localparam logic [4:0] OP_XOR = 5'd4,  OP_SLT  = 5'd5,  OP_SLL    = 5'd6,  OP_SLTU  = 5'd7;
    localparam logic [4:0] OP_SRL = 5'd8,  OP_SRA  = 5'd9,  OP_CPY1   = 5'd10, OP_CPY2  = 5'd11;
    localparam logic [4:0] OP_MUL = 5'd12, OP_MULH = 5'd13, OP_MULHSU = 5'd14, OP_MULHU = 5'd15;
    localparam logic [4:0] OP_DIV = 5'd16, OP_REM  = 5'd18;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t              state, state_nxt;
    logic                accept, start_mul, start_div, last_step;
    logic                s1, s2, neg_in;
    logic [XLEN-1:0]     a_mag, b_mag, alu_res, iter_res, dsel;
    logic [4:0]          op_q;
    logic                neg_q;
    logic [XLEN-1:0]     mcand_q;
    logic [2*XLEN-1:0]   prod_q, prod_nxt, mul_next, div_next, mfix;
    logic [CW-1:0]       cnt_q;
    logic [XLEN:0]       mul_sum, div_shift;
    logic [XLEN-1:0]     div_diff;
    logic                div_ge;
    logic [SHW-1:0]      sh;

    assign accept    = in_valid && in_ready;
    assign start_div = accept && (alu_op inside {[5'd16:5'd19]});
`ifdef ITER_ALU_FAST_MUL_EN
    assign start_mul = 1'b0;
`else
    assign start_mul = accept && (alu_op inside {[5'd12:5'd15]});
`endif
    assign last_step = (cnt_q == CW'(XLEN - 1));

    // NOTE: state and datapath registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (accept)
                    state_nxt = start_mul ? MUL : (start_div ? DIV : DONE);
                else if (state == DONE && out_ready)
                    state_nxt = IDLE;
            end
            MUL, DIV: if (last_step) state_nxt = DONE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE) || (state == DONE && out_ready);
        busy      = (state == MUL) || (state == DIV);
        out_valid = (state == DONE);
    end

    // Signed ops are run on magnitudes; neg_in records whether the final result must be negated.
    always_comb begin
        s1     = (alu_op == OP_MULH) || (alu_op == OP_MULHSU) || (alu_op == OP_DIV) || (alu_op == OP_REM);
        s2     = (alu_op == OP_MULH) || (alu_op == OP_DIV) || (alu_op == OP_REM);
        a_mag  = (s1 && in1[XLEN-1]) ? '0 - in1 : in1;
        b_mag  = (s2 && in2[XLEN-1]) ? '0 - in2 : in2;
        neg_in = (s1 && in1[XLEN-1]) ^ (s2 && in2[XLEN-1]);
        if (alu_op == OP_REM)
            neg_in = in1[XLEN-1];
        else if (alu_op == OP_DIV)
            neg_in = (in1[XLEN-1] ^ in2[XLEN-1]) && (in2 != '0);
    end

    always_comb begin
        sh      = in2[SHW-1:0];
        alu_res = '0;
        case (alu_op)
            OP_ADD:  alu_res = in1 + in2;
            OP_SUB:  alu_res = in1 - in2;
            OP_AND:  alu_res = in1 & in2;
            OP_OR:   alu_res = in1 | in2;
            OP_XOR:  alu_res = in1 ^ in2;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(in1) < $signed(in2)};
            OP_SLL:  alu_res = in1 << sh;
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, in1 < in2};
            OP_SRL:  alu_res = in1 >> sh;
            OP_SRA:  alu_res = $signed(in1) >>> sh;
            OP_CPY1: alu_res = in1;
            OP_CPY2: alu_res = in2;
`ifdef ITER_ALU_FAST_MUL_EN
            OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU: begin
                logic [2*XLEN-1:0] ext1, ext2, full;
                ext1 = {{XLEN{s1 && in1[XLEN-1]}}, in1};
                ext2 = {{XLEN{s2 && in2[XLEN-1]}}, in2};
                full = ext1 * ext2;
                alu_res = (alu_op == OP_MUL) ? full[XLEN-1:0] : full[2*XLEN-1:XLEN];
            end
`endif
            default: alu_res = '0;
        endcase
    end

    // One shift-add or restoring-divide step per cycle; the sign is applied on the last step.
    always_comb begin
        mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, (prod_q[0] ? mcand_q : '0)};
        mul_next  = {mul_sum, prod_q[XLEN-1:1]};
        div_shift = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
        div_ge    = div_shift >= {1'b0, mcand_q};
        div_diff  = div_shift[XLEN-1:0] - mcand_q;
        div_next  = {(div_ge ? div_diff : div_shift[XLEN-1:0]), prod_q[XLEN-2:0], div_ge};
        prod_nxt  = (state == MUL) ? mul_next : div_next;
        mfix      = neg_q ? '0 - mul_next : mul_next;
        dsel      = op_q[1] ? div_next[2*XLEN-1:XLEN] : div_next[XLEN-1:0];
        if (state == MUL)
            iter_res = (op_q == OP_MUL) ? mfix[XLEN-1:0] : mfix[2*XLEN-1:XLEN];
        else
            iter_res = neg_q ? '0 - dsel : dsel;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= '0;
            neg_q   <= 1'b0;
            mcand_q <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
            alu_out <= '0;
        end else if (accept) begin
            op_q  <= alu_op;
            neg_q <= neg_in;
            cnt_q <= '0;
            if (start_div) begin
                mcand_q <= b_mag;
                prod_q  <= {{XLEN{1'b0}}, a_mag};
            end else begin
                mcand_q <= a_mag;
                prod_q  <= {{XLEN{1'b0}}, b_mag};
            end
            if (!start_mul && !start_div)
                alu_out <= alu_res;
        end else if (busy) begin
            prod_q <= prod_nxt;
            cnt_q  <= cnt_q + CW'(1);
            if (last_step) begin
                cnt_q   <= '0;
                alu_out <= iter_res;
            end
        end
    end
endmodule

// File: tb/tb_iter_alu.sv
// Scoreboard bench for iter_alu (XLEN=32): expected results and accept cycles are queued at each
// accept and compared, with latency, when the DUT presents them.
module tb_iter_alu;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  alu_op = '0;
    logic [31:0] in1 = '0;
    logic [31:0] in2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] alu_out;
    logic        busy;

    iter_alu #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .alu_op(alu_op),
        .in1(in1), .in2(in2), .out_valid(out_valid), .out_ready(out_ready), .alu_out(alu_out),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] exp;
        int          acc;
        int          lat;
        logic [4:0]  op;
    } sb_t;

    sb_t  sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   measured = 0;
    bit   stream_mode = 0;
    int   stream_pops = 0;
    int   stream_prev = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        failures++;
        $display("FAIL %s bound expired", tag);
    endtask

    function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb_;
        logic signed [63:0] ps;
        logic        [63:0] pu;
        sa = a;
        sb_ = b;
        case (op)
            5'd0:  return a + b;
            5'd1:  return a - b;
            5'd2:  return a & b;
            5'd3:  return a | b;
            5'd4:  return a ^ b;
            5'd5:  return (sa < sb_) ? 32'd1 : 32'd0;
            5'd6:  return a << b[4:0];
            5'd7:  return (a < b) ? 32'd1 : 32'd0;
            5'd8:  return a >> b[4:0];
            5'd9:  return sa >>> b[4:0];
            5'd10: return a;
            5'd11: return b;
            5'd12: begin pu = {32'b0, a} * {32'b0, b}; return pu[31:0]; end
            5'd13: begin ps = 64'(sa) * 64'(sb_); return ps[63:32]; end
            5'd14: begin ps = 64'(sa) * $signed({32'b0, b}); return ps[63:32]; end
            5'd15: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
            5'd16: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return sa / sb_;
            end
            5'd17: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            5'd18: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return sa % sb_;
            end
            5'd19: return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int latency(input logic [4:0] op);
`ifdef ITER_ALU_FAST_MUL_EN
        if (op inside {[5'd16:5'd19]}) return 33;
`else
        if (op inside {[5'd12:5'd19]}) return 33;
`endif
        return 1;
    endfunction

    // Called at posedge+2; returns at posedge+2 just after the accepting edge.
    task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        in_valid = 1'b1;
        alu_op = op;
        in1 = a;
        in2 = b;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) timeout("send");
        @(posedge clk);
        #2;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() > 0) timeout("drain");
        if (n > 0) #2;
    endtask

    task automatic monitor();
        sb_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb.delete();
                measured = 0;
            end else begin
                if (out_valid && !measured) begin
                    measured = 1;
                    if (sb.size() == 0) timeout("unexpected_result");
                    else check($sformatf("latency_op%0d", sb[0].op), 64'(cyc - sb[0].acc), 64'(sb[0].lat));
                end
                if (out_valid && out_ready && sb.size() > 0) begin
                    e = sb.pop_front();
                    check($sformatf("result_op%0d", e.op), {32'b0, alu_out}, {32'b0, e.exp});
                    measured = 0;
                    if (stream_mode) begin
                        if (stream_pops > 0) check("stream_gap", 64'(cyc - stream_prev), 64'd1);
                        stream_prev = cyc;
                        stream_pops++;
                    end
                end
                if (in_valid && in_ready)
                    sb.push_back('{exp: model(alu_op, in1, in2), acc: cyc, lat: latency(alu_op), op: alu_op});
            end
        end
    endtask

    task automatic run_tests();
        int start;
        // Reset state
        #23;
        check("rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("rst_alu_out", {32'b0, alu_out}, 64'd0);
        check("rst_busy", {63'b0, busy}, 64'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #2;
        check("rst_in_ready", {63'b0, in_ready}, 64'd1);

        // Single-cycle ops
        send(5'd0, 32'h7FFF_FFFF, 32'h1);
        send(5'd9, 32'h8000_0000, 32'd4);
        send(5'd7, 32'h1, 32'hFFFF_FFFF);
        send(5'd5, 32'hFFFF_FFF0, 32'h3);
        send(5'd8, 32'h8000_0000, 32'd31);
        send(5'd10, 32'hDEAD_BEEF, 32'h1234_5678);
        send(5'd11, 32'hDEAD_BEEF, 32'h1234_5678);
        send(5'd22, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        drain();

        // Multiply
        send(5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
`ifdef ITER_ALU_FAST_MUL_EN
        check("mul_busy", {63'b0, busy}, 64'd0);
`else
        check("mul_busy", {63'b0, busy}, 64'd1);
        check("mul_in_ready", {63'b0, in_ready}, 64'd0);
`endif
        send(5'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        for (int i = 0; i < 3; i++)
            for (int op = 12; op <= 15; op++)
                send(5'(op), $urandom, $urandom);
        drain();

        // Divide, including corner cases
        send(5'd16, 32'hFFFF_FFF9, 32'd2);
        check("div_busy", {63'b0, busy}, 64'd1);
        send(5'd18, 32'hFFFF_FFF9, 32'd2);
        send(5'd17, 32'h1234_5678, 32'd0);
        send(5'd19, 32'd5, 32'd0);
        send(5'd16, 32'hFFFF_FFF9, 32'd0);
        send(5'd18, 32'hFFFF_FFF9, 32'd0);
        send(5'd16, 32'h8000_0000, 32'hFFFF_FFFF);
        send(5'd18, 32'h8000_0000, 32'hFFFF_FFFF);
        for (int i = 0; i < 2; i++)
            for (int op = 16; op <= 19; op++)
                send(5'(op), $urandom, $urandom_range(1, 100000));
        drain();

        // Back-pressure: result must hold while out_ready is low
        out_ready = 1'b0;
        send(5'd0, 32'd3, 32'd4);
        in_valid = 1'b1;
        alu_op = 5'd1;
        in1 = 32'd10;
        in2 = 32'd3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", {63'b0, out_valid}, 64'd1);
            check("hold_in_ready", {63'b0, in_ready}, 64'd0);
            check("hold_data", {32'b0, alu_out}, 64'd7);
        end
        @(posedge clk); #2;
        out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", {63'b0, in_ready}, 64'd1);
        @(posedge clk); #2;
        in_valid = 1'b0;
        drain();

        // Reset in the middle of a divide
        send(5'd17, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #2;
        check("pre_rst_busy", {63'b0, busy}, 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {63'b0, out_valid}, 64'd0);
        check("midrst_alu_out", {32'b0, alu_out}, 64'd0);
        check("midrst_busy", {63'b0, busy}, 64'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #2;
        check("post_rst_in_ready", {63'b0, in_ready}, 64'd1);
        send(5'd0, 32'd5, 32'd6);
        drain();

        // Streaming: one result per cycle
        stream_mode = 1'b1;
        start = cyc;
        send(5'd0, 32'd1, 32'd2);
        send(5'd1, 32'd1, 32'd2);
        send(5'd2, 32'hF0F0_F0F0, 32'hFF00_FF00);
        send(5'd3, 32'hF0F0_F0F0, 32'h0F0F_0000);
        send(5'd4, 32'hAAAA_AAAA, 32'hFFFF_0000);
        send(5'd5, 32'd5, 32'hFFFF_FFFF);
        send(5'd6, 32'h0000_0001, 32'hFFFF_FFE5);
        send(5'd25, 32'd9, 32'd9);
        check("stream_cycles", 64'(cyc - start), 64'd8);
        drain();
        check("stream_pops", 64'(stream_pops), 64'd8);
        stream_mode = 1'b0;
    endtask

    initial begin
        fork
            monitor();
            run_tests();
        join_any
        disable fork;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
